serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands DIGIT bits per clock, starting from the least significant digit, through a registered carry. It extends the team's combinational full-adder cell into a sequential datapath block. It provides a start/busy/done handshake, an add/subtract mode, carry-out and signed overflow. It trades latency for area in the arithmetic datapath.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_digit_adder.sv | 47 ++++
 rtl/serial_adder.sv | 146 ++++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and a
// parameter sanity helper used at elaboration time.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when the operand width splits evenly into whole digits.
  function automatic bit width_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Single-bit full-adder cell and the DIGIT-bit ripple chain built from it.
// The chain also reports the carry into its top bit so the caller can form
// signed overflow on the final digit.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_top_o
);

  // c[k] is the carry into bit k; c[DIGIT] leaves the digit.
  logic [DIGIT:0] c;

  assign c[0] = c_i;

  for (genvar k = 0; k < DIGIT; k++) begin : g_bit
    full_adder u_fa (
      .a_i (a_i[k]),
      .b_i (b_i[k]),
      .c_i (c[k]),
      .s_o (s_o[k]),
      .c_o (c[k+1])
    );
  end

  assign c_o     = c[DIGIT];
  assign c_top_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor. Operands are consumed DIGIT bits per clock,
// LSB digit first, with the carry held in a register between digits.
// Handshake: start is accepted only when busy=0 (IDLE or DONE); done is a
// one-cycle pulse and sum/cout/ovf are valid from that cycle until the next
// result or reset. start while busy is dropped, not queued.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_e           state_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dctop;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] sr_next;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .c_i     (c_q),
    .s_o     (dsum),
    .c_o     (dco),
    .c_top_o (dctop)
  );

  assign accept  = start && (state_q != RUN);
  assign last    = (cnt_q == CW'(NDIG - 1));
  // New digit enters at the top; older digits move toward bit 0.
  assign sr_next = WIDTH'({dsum, sr_q} >> DIGIT);

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, one digit per RUN cycle.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sr_d   = sr_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (accept) begin
      // Subtract as a + ~b + ~cin, so cin acts as a borrow-in.
      a_d   = a;
      b_d   = sub ? ~b : b;
      c_d   = sub ? ~cin : cin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      sr_d  = sr_next;
      c_d   = dco;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        sum_d  = sr_next;
        cout_d = dco;
        ovf_d  = dco ^ dctop;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4.
// Drivers push expected {done cycle, sum, cout, ovf} into per-DUT queues;
// monitors pop and compare whenever done is seen.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int N8  = 8;
  localparam int N16 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  state_e      state8;

  logic        start16 = 0, cin16 = 0, sub16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  state_e      state16;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sub(sub8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .ovf(ovf8), .state_o(state8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .sub(sub16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
    .ovf(ovf16), .state_o(state16)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [41:0] exp8_q[$];   // {done_cycle[31:0], sum[7:0], cout, ovf}
  logic [49:0] exp16_q[$];  // {done_cycle[31:0], sum[15:0], cout, ovf}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [41:0] e;
    if (done8 === 1'b1) begin
      if (exp8_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done8 at cycle %0d: got done=1 sum=0x%0h, required no done", cyc, sum8);
      end else begin
        e = exp8_q.pop_front();
        chk("done8_cycle", 64'(cyc), 64'(e[41:10]));
        chk("sum8", 64'(sum8), 64'(e[9:2]));
        chk("cout8", 64'(cout8), 64'(e[1]));
        chk("ovf8", 64'(ovf8), 64'(e[0]));
      end
    end
  end

  always @(negedge clk) begin
    logic [49:0] e;
    if (done16 === 1'b1) begin
      if (exp16_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done16 at cycle %0d: got done=1 sum=0x%0h, required no done", cyc, sum16);
      end else begin
        e = exp16_q.pop_front();
        chk("done16_cycle", 64'(cyc), 64'(e[49:18]));
        chk("sum16", 64'(sum16), 64'(e[17:2]));
        chk("cout16", 64'(cout16), 64'(e[1]));
        chk("ovf16", 64'(ovf16), 64'(e[0]));
      end
    end
  end

  // ---------------- drivers ----------------
  // Issue one 8-bit op and follow it to its DONE cycle. If poke is in
  // 1..N8-2, start is pulsed with scrambled operands that many cycles into RUN.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic s, input logic [7:0] es, input logic ec,
                         input logic eo, input int poke);
    a8 = a; b8 = b; cin8 = ci; sub8 = s; start8 = 1'b1;
    exp8_q.push_back({32'(cyc + 1 + N8), es, ec, eo});
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 1; i < N8; i++) begin
      if (i == poke) begin
        start8 = 1'b1; a8 = ~a; b8 = ~b; sub8 = ~s; cin8 = ~ci;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      chk("busy8_run", 64'(busy8), 64'd1);
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("busy8_done", 64'(busy8), 64'd0);
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic s, input logic [15:0] es, input logic ec,
                          input logic eo);
    a16 = a; b16 = b; cin16 = ci; sub16 = s; start16 = 1'b1;
    exp16_q.push_back({32'(cyc + 1 + N16), es, ec, eo});
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int i = 1; i < N16; i++) begin
      @(posedge clk); #1;
      chk("busy16_run", 64'(busy16), 64'd1);
    end
    @(posedge clk); #1;
    chk("busy16_done", 64'(busy16), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got no end of test, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_sum8", 64'(sum8), 64'd0);
    chk("rst_cout8", 64'(cout8), 64'd0);
    chk("rst_ovf8", 64'(ovf8), 64'd0);
    chk("rst_state8", 64'(state8), 64'(IDLE));
    chk("rst_sum16", 64'(sum16), 64'd0);
    chk("rst_busy16", 64'(busy16), 64'd0);
    @(posedge clk); #1;

    // plain adds, carry-out and signed overflow (back-to-back pair)
    run_op8(8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, -1);
    repeat (2) @(posedge clk); #1;
    run_op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    run_op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, -1);
    run_op8(8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, -1);
    repeat (2) @(posedge clk); #1;

    // subtracts, including borrow-in
    run_op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, -1);
    run_op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, -1);
    run_op8(8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, -1);
    repeat (2) @(posedge clk); #1;

    // start pulsed mid-RUN is dropped; start held in DONE is accepted
    run_op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 3);
    run_op8(8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, -1);
    repeat (2) @(posedge clk); #1;

    // reset 4 cycles into RUN discards the operation
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back({32'(cyc + 1 + N8), 8'h77, 1'b0, 1'b0});
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp8_q.pop_back());
    chk("midrun_rst_busy8", 64'(busy8), 64'd0);
    chk("midrun_rst_done8", 64'(done8), 64'd0);
    chk("midrun_rst_sum8", 64'(sum8), 64'd0);
    chk("midrun_rst_cout8", 64'(cout8), 64'd0);
    chk("midrun_rst_ovf8", 64'(ovf8), 64'd0);
    repeat (12) @(posedge clk); #1;
    run_op8(8'h0A, 8'h05, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, -1);
    repeat (2) @(posedge clk); #1;

    // 16-bit operands, 4-bit digits
    run_op16(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    run_op16(16'h7FF0, 16'h0010, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;

    chk("exp8_drained", 64'(exp8_q.size()), 64'd0);
    chk("exp16_drained", 64'(exp16_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
